alu_serial: RTL and testbench
=============================

Name: alu_serial

Overview:
- Parametrised multi-cycle successor to the single-bit ALU slice. Computes AND, OR, ADD, SUB (A + ~B + 1) and XOR on WIDTH-bit operands, DIGIT bits per clock, using a start/done handshake.
- Sits beside the CPU datapath as a low-area ALU. Reports carry, zero, overflow and negative flags at completion.

Parameters:
- WIDTH, 16: operand and result width in bits. Must be ≥ 2.
- DIGIT, 1: bits processed per cycle. Must divide WIDTH. Latency N = WIDTH/DIGIT.

Ports:
- Clock  input  1  single rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request. Accepted only on an edge where Busy=0.
- A  input  WIDTH  operand A. Sampled on the accept edge.
- B  input  WIDTH  operand B. Sampled on the accept edge.
- BInvert  input  1  inverts B before every operation; also the carry-in for the arithmetic op. Sampled on the accept edge.
- Operation  input  2  00 AND, 01 OR, 10 ADD/SUB, 11 XOR. Sampled on the accept edge.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse when Result and flags update.
- Result  output  WIDTH  last completed result. Held stable until the next Done.
- CarryOut  output  1  carry out of the MSB (arithmetic op only).
- Zero  output  1  Result == 0 (all ops).
- Overflow  output  1  signed overflow (arithmetic op only).
- Negative  output  1  Result[WIDTH-1] (all ops).

Behaviour:
- Reset (synchronous): Busy, Done, Result, CarryOut, Zero, Overflow, Negative all 0. FSM goes to IDLE. Internal counter, shift registers and carry cleared.
- FSM has two states, IDLE and RUN.
- IDLE → RUN on an edge with Start=1 (the accept edge). On that edge:
  - A, Operation, BInvert are captured.
  - B is captured as B ^ {WIDTH{BInvert}}.
  - Carry register loads BInvert when Operation=10, else 0.
  - Digit counter loads 0. Busy=1 from the next cycle.
- RUN: each edge processes the DIGIT least-significant unprocessed bits. Per bit: the 1-bit slice function on (a, b', carry). Carry ripples across the DIGIT bits, then is registered. Counter increments.
- Completion on the N-th edge after the accept edge:
  - Result, flags and Done=1 update together; Busy=0; FSM → IDLE.
  - Done stays high for that one cycle only.
- Latency: Done asserts exactly N cycles after the accept edge (16 for defaults; 4 for DIGIT=4).
- Result and flags never change except on a Done edge or on reset. Intermediate bits live in an internal shift register.
- Arithmetic flags:
  - CarryOut = carry out of bit WIDTH-1.
  - Overflow = carry into MSB XOR carry out of MSB.
- Logic ops (00, 01, 11): CarryOut=0, Overflow=0. BInvert still inverts B, so AND with BInvert gives A & ~B.
- Start while Busy=1 is ignored: no capture and no effect on the running operation.
- Start on the Done cycle (Busy=0) is accepted: back-to-back operations with no bubble. The next Done follows N cycles later.
- Reset mid-RUN aborts the operation: no Done is produced and outputs return to reset values on that edge.
- Reset and Start on the same edge: reset wins and the request is dropped.
- Operand inputs are don't-care except on the accept edge.

Test Plan:
- WIDTH=16, DIGIT=1; ADD, A=0x7FFF, B=0x0001, BInvert=0 → Result=0x8000, Overflow=1, Negative=1, CarryOut=0, Zero=0. Done exactly 16 cycles after accept; Busy high for those 16 cycles.
- SUB (Op=10, BInvert=1), 0x0005−0x0005 → 0x0000, Zero=1, CarryOut=1, Overflow=0. SUB 0x0003−0x0005 → 0xFFFE, CarryOut=0, Negative=1, Overflow=0.
- Logic ops, A=0xF0F0, B=0xFF00:
  - AND → 0xF000; OR → 0xFFF0; XOR → 0x0FF0.
  - AND with BInvert=1 → 0x00F0.
  - CarryOut=0 and Overflow=0 in every case.
- Start ADD 1+1, then pulse Start with A=0x1234 at cycle 5 of the run → ignored; Result=0x0002. Start ADD 2+3 on the Done cycle → accepted; Result=0x0005 with Done 16 cycles later; Result holds 0x0002 until then.
- Reset asserted at cycle 7 of a run → next cycle Busy=0, Done=0, Result=0. No Done for at least 20 further cycles. A fresh Start afterwards completes normally.
- DIGIT=4, ADD 0xFFFF+0x0001 → Result=0x0000, CarryOut=1, Zero=1, Overflow=0, Done 4 cycles after accept.

Source files
------------

// File: rtl/alu_serial.sv
// Multi-cycle serial ALU: AND/OR/ADD-SUB/XOR on WIDTH-bit operands, DIGIT bits per clock,
// with a start/done handshake and carry/zero/overflow/negative flags at completion.
module alu_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_binvert,
  input  logic [1:0]       i_op,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry_out,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_negative
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic [1:0]       r_op;
  logic             r_carry;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out, r_zero, r_overflow, r_negative;

  logic             w_accept, w_last, w_arith;
  logic [DIGIT-1:0] w_digit;
  logic             w_c_msb_in, w_c_out;
  logic [WIDTH-1:0] w_res_next;

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_accept  = 1'b1;
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (r_cnt == CntW'(N - 1)) begin
          w_last    = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // One DIGIT-wide group of bit slices; carry ripples LSB to MSB within the group.
  always_comb begin : slice_comb
    logic v_c;
    v_c        = r_carry;
    w_c_msb_in = 1'b0;
    w_digit    = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      if (i == int'(DIGIT) - 1) w_c_msb_in = v_c;
      case (r_op)
        2'b00:   w_digit[i] = r_a[i] & r_b[i];
        2'b01:   w_digit[i] = r_a[i] | r_b[i];
        2'b10:   w_digit[i] = r_a[i] ^ r_b[i] ^ v_c;
        default: w_digit[i] = r_a[i] ^ r_b[i];
      endcase
      v_c = (r_a[i] & r_b[i]) | (v_c & (r_a[i] ^ r_b[i]));
    end
    w_c_out = v_c;
  end

  // Result bits enter at the top so the first digit ends up in the LSBs after N shifts.
  assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_digit) << (WIDTH - DIGIT));
  assign w_arith    = (r_op == 2'b10);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_op        <= 2'b00;
      r_carry     <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_negative  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_a     <= i_a;
        r_b     <= i_b ^ {WIDTH{i_binvert}};
        r_op    <= i_op;
        r_carry <= (i_op == 2'b10) ? i_binvert : 1'b0;
        r_cnt   <= '0;
        r_res   <= '0;
      end else if (r_state == StRun) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_carry <= w_c_out;
        r_res   <= w_res_next;
        r_cnt   <= r_cnt + CntW'(1);
        if (w_last) begin
          r_done      <= 1'b1;
          r_result    <= w_res_next;
          r_carry_out <= w_arith & w_c_out;
          r_overflow  <= w_arith & (w_c_msb_in ^ w_c_out);
          r_zero      <= (w_res_next == '0);
          r_negative  <= w_res_next[WIDTH-1];
        end
      end
    end
  end

  assign o_busy      = (r_state == StRun);
  assign o_done      = r_done;
  assign o_result    = r_result;
  assign o_carry_out = r_carry_out;
  assign o_zero      = r_zero;
  assign o_overflow  = r_overflow;
  assign o_negative  = r_negative;

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial: a DIGIT=1 and a DIGIT=4 instance share one set of inputs.
module tb_alu_serial;

  logic        clk = 1'b0;
  logic        rst, start, binv;
  logic [15:0] a, b;
  logic [1:0]  op;

  logic        busy1, done1, co1, z1, ov1, neg1;
  logic [15:0] res1;
  logic        busy4, done4, co4, z4, ov4, neg4;
  logic [15:0] res4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_serial #(.WIDTH(16), .DIGIT(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b), .i_binvert(binv), .i_op(op),
    .o_busy(busy1), .o_done(done1), .o_result(res1), .o_carry_out(co1), .o_zero(z1),
    .o_overflow(ov1), .o_negative(neg1)
  );

  alu_serial #(.WIDTH(16), .DIGIT(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b), .i_binvert(binv), .i_op(op),
    .o_busy(busy4), .o_done(done4), .o_result(res4), .o_carry_out(co4), .o_zero(z4),
    .o_overflow(ov4), .o_negative(neg4)
  );

  // Drives a request; returns #1 after the accept edge.
  task automatic do_start(input logic [15:0] ia, input logic [15:0] ib, input logic ibinv,
                          input logic [1:0] iop);
    a = ia; b = ib; binv = ibinv; op = iop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until Done (sel=0: DIGIT=1 instance, sel=1: DIGIT=4); cyc=-1 on timeout.
  task automatic wait_done(input bit sel, output int cyc, output int nbusy);
    cyc   = -1;
    nbusy = sel ? int'(busy4) : int'(busy1);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (sel ? done4 : done1) begin
        cyc = k;
        break;
      end
      nbusy += sel ? int'(busy4) : int'(busy1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; binv = 1'b0; op = 2'b00;
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if ({busy1, done1, res1, co1, z1, ov1, neg1} !== 22'd0) begin
      n_fail++; $display("FAIL reset_outputs_d1: got %h expected 0",
                         {busy1, done1, res1, co1, z1, ov1, neg1});
    end
    n_tests++;
    if ({busy4, done4, res4, co4, z4, ov4, neg4} !== 22'd0) begin
      n_fail++; $display("FAIL reset_outputs_d4: got %h expected 0",
                         {busy4, done4, res4, co4, z4, ov4, neg4});
    end
    // Start together with reset must be dropped.
    a = 16'h0001; b = 16'h0001; op = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (busy1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_start_dropped: busy got %b expected 0", busy1);
    end
  endtask

  task automatic test_add_overflow;
    int cyc, nbusy;
    do_start(16'h7FFF, 16'h0001, 1'b0, 2'b10);
    wait_done(1'b0, cyc, nbusy);
    n_tests++;
    if (cyc !== 16) begin
      n_fail++; $display("FAIL add_latency: got %0d expected 16", cyc);
    end
    n_tests++;
    if (nbusy !== 16) begin
      n_fail++; $display("FAIL add_busy_cycles: got %0d expected 16", nbusy);
    end
    n_tests++;
    if (busy1 !== 1'b0) begin
      n_fail++; $display("FAIL add_busy_at_done: got %b expected 0", busy1);
    end
    n_tests++;
    if (res1 !== 16'h8000) begin
      n_fail++; $display("FAIL add_result: got %h expected 8000", res1);
    end
    n_tests++;  // {carry, zero, overflow, negative}
    if ({co1, z1, ov1, neg1} !== 4'b0011) begin
      n_fail++; $display("FAIL add_flags: got %b expected 0011", {co1, z1, ov1, neg1});
    end
    @(posedge clk); #1;
    n_tests++;
    if (done1 !== 1'b0) begin
      n_fail++; $display("FAIL done_one_cycle: got %b expected 0", done1);
    end
  endtask

  task automatic test_sub;
    int cyc, nbusy;
    do_start(16'h0005, 16'h0005, 1'b1, 2'b10);
    wait_done(1'b0, cyc, nbusy);
    n_tests++;
    if ({res1, co1, z1, ov1, neg1} !== {16'h0000, 4'b1100}) begin
      n_fail++; $display("FAIL sub_5_5: got %h/%b expected 0000/1100", res1, {co1, z1, ov1, neg1});
    end
    do_start(16'h0003, 16'h0005, 1'b1, 2'b10);
    wait_done(1'b0, cyc, nbusy);
    n_tests++;
    if ({res1, co1, z1, ov1, neg1} !== {16'hFFFE, 4'b0001}) begin
      n_fail++; $display("FAIL sub_3_5: got %h/%b expected fffe/0001", res1, {co1, z1, ov1, neg1});
    end
  endtask

  task automatic test_logic;
    logic [1:0]  t_op  [4] = '{2'b00, 2'b01, 2'b11, 2'b00};
    logic        t_inv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] t_exp [4] = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h00F0};
    int cyc, nbusy;
    for (int i = 0; i < 4; i++) begin
      do_start(16'hF0F0, 16'hFF00, t_inv[i], t_op[i]);
      wait_done(1'b0, cyc, nbusy);
      n_tests++;
      if (res1 !== t_exp[i]) begin
        n_fail++; $display("FAIL logic_result[%0d]: got %h expected %h", i, res1, t_exp[i]);
      end
      n_tests++;
      if ({co1, ov1} !== 2'b00) begin
        n_fail++; $display("FAIL logic_co_ov[%0d]: got %b expected 00", i, {co1, ov1});
      end
    end
  endtask

  task automatic test_back_to_back;
    int cyc, nbusy;
    do_start(16'h0001, 16'h0001, 1'b0, 2'b10);
    repeat (4) @(posedge clk);
    @(negedge clk);
    a = 16'h1234; start = 1'b1;  // while busy: must be ignored
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, cyc, nbusy);
    n_tests++;
    if (cyc !== 11) begin
      n_fail++; $display("FAIL ignored_start_latency: got %0d expected 11", cyc);
    end
    n_tests++;
    if (res1 !== 16'h0002) begin
      n_fail++; $display("FAIL ignored_start_result: got %h expected 0002", res1);
    end
    do_start(16'h0002, 16'h0003, 1'b0, 2'b10);  // on the Done cycle
    n_tests++;
    if (busy1 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: busy got %b expected 1", busy1);
    end
    repeat (8) @(posedge clk); #1;
    n_tests++;
    if (res1 !== 16'h0002) begin
      n_fail++; $display("FAIL b2b_result_hold: got %h expected 0002", res1);
    end
    wait_done(1'b0, cyc, nbusy);
    n_tests++;
    if (cyc !== 8) begin
      n_fail++; $display("FAIL b2b_latency: got %0d expected 8 (16 total)", cyc);
    end
    n_tests++;
    if (res1 !== 16'h0005) begin
      n_fail++; $display("FAIL b2b_result: got %h expected 0005", res1);
    end
  endtask

  task automatic test_reset_mid_run;
    int cyc, nbusy, ndone;
    do_start(16'h00FF, 16'h0F00, 1'b0, 2'b01);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if ({busy1, done1, res1} !== 18'd0) begin
      n_fail++; $display("FAIL midrun_reset: got %h expected 0", {busy1, done1, res1});
    end
    ndone = 0;
    repeat (20) begin
      @(posedge clk); #1;
      ndone += int'(done1);
    end
    n_tests++;
    if (ndone !== 0) begin
      n_fail++; $display("FAIL midrun_no_done: got %0d dones expected 0", ndone);
    end
    do_start(16'h0100, 16'h0023, 1'b0, 2'b10);
    wait_done(1'b0, cyc, nbusy);
    n_tests++;
    if (cyc !== 16 || res1 !== 16'h0123) begin
      n_fail++; $display("FAIL after_reset_op: got %0d/%h expected 16/0123", cyc, res1);
    end
  endtask

  task automatic test_digit4;
    int cyc, nbusy;
    do_start(16'hFFFF, 16'h0001, 1'b0, 2'b10);
    wait_done(1'b1, cyc, nbusy);
    n_tests++;
    if (cyc !== 4 || nbusy !== 4) begin
      n_fail++; $display("FAIL d4_latency: got %0d/%0d expected 4/4", cyc, nbusy);
    end
    n_tests++;
    if ({res4, co4, z4, ov4, neg4} !== {16'h0000, 4'b1100}) begin
      n_fail++; $display("FAIL d4_add: got %h/%b expected 0000/1100", res4, {co4, z4, ov4, neg4});
    end
    wait_done(1'b0, cyc, nbusy);  // let the DIGIT=1 instance drain
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub();
    test_logic();
    test_back_to_back();
    test_reset_mid_run();
    test_digit4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
